ahb_sram_responder: RTL and testbench

- AHB-Lite responder with word-organised internal memory; the target the DMA read and write initiators talk to (source and destination buffers).
- Supports byte, halfword and word transfers with byte-lane strobes.
- Supports configurable wait states, read-after-write forwarding, and two-cycle ERROR responses for illegal accesses.
- Sits on the AHB matrix alongside the system SRAM; one instance per buffer region.

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_lane_decode.sv | 16 +
 rtl/ahb_sram_responder.sv | 87 ++++++++
 tb/tb_ahb_sram_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer codes, responder FSM states and a byte-lane merge helper
package ahb_pkg;
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;
   localparam logic [2:0] HS_BYTE   = 3'b000;
   localparam logic [2:0] HS_HALF   = 3'b001;
   localparam logic [2:0] HS_WORD   = 3'b010;
   localparam logic HR_OKAY  = 1'b0;
   localparam logic HR_ERROR = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] wdata,
                                               input logic [3:0] strobe);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = strobe[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
      return w;
   endfunction
endpackage

// File: rtl/ahb_lane_decode.sv
// ahb_lane_decode: HSIZE and low address bits to byte strobes plus alignment/size legality
module ahb_lane_decode
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] strobe,
   output logic       misaligned,
   output logic       bad_size
);
   assign strobe     = size == HS_BYTE ? 4'b0001 << addr_lo :
                       size == HS_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                       size == HS_WORD ? 4'b1111 : 4'b0000;
   assign misaligned = (size == HS_HALF && addr_lo[0]) || (size == HS_WORD && addr_lo != 2'b00);
   assign bad_size   = size > HS_WORD;
endmodule

// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite word SRAM target with wait states, write forwarding and two-cycle ERROR
module ahb_sram_responder
   import ahb_pkg::*;
#(
   parameter int AW          = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP
);
   localparam logic [1:0] WS_LOAD = 2'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   logic [31:0]   mem [0:2**AW-1];
   state_t        st, nxt, launch;
   logic [AW-1:0] addr_q, rd_idx;
   logic          wr_q;
   logic [3:0]    strb_q, strobe;
   logic [1:0]    cnt;
   logic [31:0]   rdata, rd_word;
   logic          misaligned, bad_size, accept, legal, ready_st, rd_next, commit;
   logic          unused_ok;

   ahb_lane_decode u_dec (
      .size       (HSIZE),
      .addr_lo    (HADDR[1:0]),
      .strobe     (strobe),
      .misaligned (misaligned),
      .bad_size   (bad_size)
   );

   assign unused_ok = ^HBURST;
   assign accept    = HSEL & (HTRANS == HT_NONSEQ || HTRANS == HT_SEQ) & HREADY;
   assign legal     = !misaligned && !bad_size && (HADDR >> (AW + 2)) == 32'd0;
   assign ready_st  = st == ST_IDLE || st == ST_DATA || st == ST_ERR2;
   assign launch    = !legal ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_DATA;
   assign commit    = st == ST_DATA && wr_q;

   always_comb begin
      nxt = st == ST_WAIT ? (cnt == 2'd0 ? ST_DATA : ST_WAIT) :
            st == ST_ERR1 ? ST_ERR2 :
            accept ? launch : ST_IDLE;
   end

   // With no wait states the read word is taken at the address edge, where the previous write commits
   assign rd_idx  = st == ST_WAIT ? addr_q : HADDR[AW+1:2];
   assign rd_word = commit && addr_q == rd_idx ? merge_lanes(mem[rd_idx], HWDATA, strb_q) : mem[rd_idx];
   assign rd_next = nxt == ST_DATA && !(st == ST_WAIT ? wr_q : HWRITE);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         st     <= ST_IDLE;
         addr_q <= '0;
         wr_q   <= 1'b0;
         strb_q <= 4'b0;
         cnt    <= 2'd0;
         rdata  <= 32'd0;
      end else begin
         st    <= nxt;
         rdata <= rd_next ? rd_word : 32'd0;
         cnt   <= st == ST_WAIT ? cnt - 2'd1 : WS_LOAD;
         if (accept && ready_st) begin
            addr_q <= HADDR[AW+1:2];
            wr_q   <= HWRITE;
            strb_q <= strobe;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (commit) mem[addr_q] <= merge_lanes(mem[addr_q], HWDATA, strb_q);
   end

   assign HREADYOUT = !(st == ST_WAIT || st == ST_ERR1);
   assign HRESP     = st == ST_ERR1 || st == ST_ERR2 ? HR_ERROR : HR_OKAY;
   assign HRDATA    = rdata;
endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb_ahb_sram_responder: two responders (0 and 2 wait states) on a small bus mux, scoreboard-checked
module tb_ahb_sram_responder;
   import ahb_pkg::*;

   typedef struct {
      logic [1:0]  sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        resp;
      int          waits;
   } exp_t;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b1;
   logic        hsel0 = 1'b0, hsel2 = 1'b0;
   logic [31:0] HADDR = '0, HWDATA = '0;
   logic [1:0]  HTRANS = HT_IDLE;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = HS_WORD, HBURST = 3'b000;
   logic        rdy0, rdy2, resp0, resp2, dp_tgt;
   logic [31:0] rdata0, rdata2;
   wire         hready = dp_tgt ? rdy2 : rdy0;
   wire         hresp = dp_tgt ? resp2 : resp0;
   wire  [31:0] hrdata = dp_tgt ? rdata2 : rdata0;

   txn_t        txq[$];
   exp_t        sb[$];
   logic [31:0] mm[int];
   int          n_cmp = 0, n_bad = 0;
   logic        mon_en = 1'b0, dp_act = 1'b0, idle_sel = 1'b0;
   int          waits = 0;

   always #5 PCLK = ~PCLK;

   ahb_sram_responder #(.AW(10), .WAIT_STATES(0)) u0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready), .HREADYOUT(rdy0),
      .HRDATA(rdata0), .HRESP(resp0));

   ahb_sram_responder #(.AW(10), .WAIT_STATES(2)) u2 (
      .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hready), .HREADYOUT(rdy2),
      .HRDATA(rdata2), .HRESP(resp2));

   // Data-phase owner drives the shared HREADY/HRDATA/HRESP
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) dp_tgt <= 1'b0;
      else if (hready) dp_tgt <= hsel2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic add(input logic [1:0] sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input string tag);
      txn_t        t;
      exp_t        e;
      int          key, lane;
      bit          ill;
      logic [31:0] w;
      t = '{sel, trans, wr, size, addr, wdata};
      txq.push_back(t);
      if (sel == 2'd0 || !trans[1]) return;
      ill = size > 3'd2 || (addr & ((32'd1 << size) - 32'd1)) != 0 || addr >= 32'h1000;
      key = (sel == 2'd2 ? 4096 : 0) + int'(addr[11:2]);
      e.tag = tag;
      e.resp = ill;
      e.waits = ill ? 1 : (sel == 2'd2 ? 2 : 0);
      e.rdata = 32'd0;
      w = mm.exists(key) ? mm[key] : 32'd0;
      if (!ill && wr) begin
         for (int i = 0; i < (1 << size); i++) begin
            lane = int'(addr[1:0]) + i;
            w[8*lane +: 8] = wdata[8*lane +: 8];
         end
         mm[key] = w;
      end
      if (!ill && !wr) e.rdata = w;
      sb.push_back(e);
   endtask

   task automatic drive(input txn_t t);
      hsel0  = t.sel == 2'd1;
      hsel2  = t.sel == 2'd2;
      HTRANS = t.trans;
      HWRITE = t.wr;
      HSIZE  = t.size;
      HADDR  = t.addr;
   endtask

   task automatic wait_ready();
      logic r;
      int   n;
      n = 0;
      do begin
         @(negedge PCLK);
         r = hready;
         @(posedge PCLK);
         n++;
      end while (!r && n < 50);
      if (!r) check("hready_timeout", {31'd0, r}, 32'd1);
      #1;
   endtask

   task automatic run();
      txn_t t;
      while (txq.size() > 0) begin
         t = txq.pop_front();
         drive(t);
         wait_ready();
         HWDATA = t.wdata;
      end
      t = '{2'd0, HT_IDLE, 1'b0, HS_WORD, 32'd0, 32'd0};
      drive(t);
      wait_ready();
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (!mon_en || !PRESETn) begin
            dp_act = 1'b0;
            idle_sel = 1'b0;
            waits = 0;
         end else begin
            if (dp_act) begin
               if (hready) begin
                  if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                  else begin
                     e = sb.pop_front();
                     check({e.tag, "_rdata"}, hrdata, e.rdata);
                     check({e.tag, "_resp"}, {31'd0, hresp}, {31'd0, e.resp});
                     check({e.tag, "_waits"}, waits, e.waits);
                  end
                  waits = 0;
               end else begin
                  waits++;
                  if (sb.size() > 0) check({sb[0].tag, "_wait_resp"}, {31'd0, hresp}, {31'd0, sb[0].resp});
               end
            end else if (idle_sel) begin
               check("idle_ready", {31'd0, hready}, 32'd1);
               check("idle_resp", {31'd0, hresp}, 32'd0);
               check("idle_rdata", hrdata, 32'd0);
            end
            if (hready) begin
               dp_act   = (hsel0 || hsel2) && HTRANS[1];
               idle_sel = (hsel0 || hsel2) && !HTRANS[1];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  sz;
      logic [31:0] a;
      #2 PRESETn = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_ready0", {31'd0, rdy0}, 32'd1);
      check("rst_resp0", {31'd0, resp0}, 32'd0);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_ready2", {31'd0, rdy2}, 32'd1);
      check("rst_resp2", {31'd0, resp2}, 32'd0);
      check("rst_rdata2", rdata2, 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      mon_en = 1'b1;

      add(1, HT_NONSEQ, 1, HS_WORD, 'h00, 'h01234567, "w0");
      add(1, HT_NONSEQ, 1, HS_WORD, 'h10, 'hDEADBEEF, "w10");
      add(1, HT_NONSEQ, 0, HS_WORD, 'h10, 0, "fwd_word");
      add(1, HT_NONSEQ, 1, HS_BYTE, 'h11, 'hAAAAAAAA, "wb11");
      add(1, HT_NONSEQ, 0, HS_WORD, 'h10, 0, "fwd_byte");
      add(1, HT_NONSEQ, 1, HS_WORD, 'h20, 0, "w20");
      add(1, HT_NONSEQ, 1, HS_HALF, 'h22, 'h12345678, "wh22");
      add(1, HT_NONSEQ, 0, HS_WORD, 'h20, 0, "r20");
      add(1, HT_NONSEQ, 0, HS_HALF, 'h20, 0, "rh20");
      add(1, HT_NONSEQ, 0, HS_HALF, 'h03, 0, "err_mis");
      add(1, HT_NONSEQ, 0, 3'b011, 'h00, 0, "err_size");
      add(1, HT_NONSEQ, 1, HS_WORD, 'h1000, 'hFFFFFFFF, "err_range");
      add(1, HT_NONSEQ, 0, HS_WORD, 'h00, 0, "r0_after_err");
      add(1, HT_NONSEQ, 1, HS_WORD, 'hFFC, 'h5A5A5A5A, "w_last");
      add(1, HT_NONSEQ, 0, HS_WORD, 'hFFC, 0, "r_last");
      add(1, HT_IDLE, 1, HS_WORD, 'h10, 0, "idle");
      add(1, HT_BUSY, 1, HS_WORD, 'h10, 0, "busy");
      add(1, HT_NONSEQ, 0, HS_WORD, 'h10, 0, "r10_after_idle");
      for (int i = 0; i < 8; i++) add(1, HT_NONSEQ, 1, HS_WORD, 'h40 + 4 * i, $urandom, "rnd_init");
      for (int i = 0; i < 24; i++) begin
         sz = 3'($urandom_range(0, 2));
         a = 32'h40 + (32'($urandom_range(0, 31)) & ~((32'd1 << sz) - 32'd1));
         add(1, HT_NONSEQ, 1'($urandom_range(0, 1)), sz, a, $urandom, "rnd");
      end
      run();

      add(2, HT_NONSEQ, 1, HS_WORD, 'h00, 'hCAFEF00D, "ws_w0");
      add(2, HT_NONSEQ, 0, HS_WORD, 'h00, 0, "ws_r0");
      for (int i = 0; i < 4; i++)
         add(2, i == 0 ? HT_NONSEQ : HT_SEQ, 1, HS_WORD, 'h04 + 4 * i, 'h11111111 * (i + 1), "ws_wseq");
      for (int i = 0; i < 4; i++)
         add(2, i == 0 ? HT_NONSEQ : HT_SEQ, 0, HS_WORD, 'h04 + 4 * i, 0, "ws_rseq");
      add(2, HT_NONSEQ, 0, HS_HALF, 'h03, 0, "ws_err");
      add(2, HT_NONSEQ, 0, HS_WORD, 'h08, 0, "ws_r8");
      run();

      for (int i = 0; i < 8; i++) add(1, HT_NONSEQ, 1, HS_WORD, 4 * i, 'h50000000 + 'h01010101 * i, "src_fill");
      run();
      for (int i = 0; i < 8; i++) begin
         add(1, HT_NONSEQ, 0, HS_WORD, 4 * i, 0, "dma_rd");
         add(2, HT_NONSEQ, 1, HS_WORD, 'h100 + 4 * i, mm[i], "dma_wr");
      end
      for (int i = 0; i < 8; i++) add(2, i == 0 ? HT_NONSEQ : HT_SEQ, 0, HS_WORD, 'h100 + 4 * i, 0, "dma_chk");
      run();

      mon_en = 1'b0;
      hsel2 = 1'b1;
      HTRANS = HT_NONSEQ;
      HWRITE = 1'b1;
      HSIZE = HS_WORD;
      HADDR = 'h100;
      @(posedge PCLK);
      #1;
      HWDATA = 'hBAD0BAD0;
      hsel2 = 1'b0;
      HTRANS = HT_IDLE;
      @(negedge PCLK);
      check("rst_in_wait_ready", {31'd0, rdy2}, 32'd0);
      PRESETn = 1'b0;
      #1;
      check("rst_abort_ready", {31'd0, rdy2}, 32'd1);
      check("rst_abort_resp", {31'd0, resp2}, 32'd0);
      check("rst_abort_rdata", rdata2, 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      mon_en = 1'b1;
      add(2, HT_NONSEQ, 0, HS_WORD, 'h100, 0, "rst_keep");
      run();

      check("sb_drain", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
